addsub_digit_serial: RTL and testbench

//  Parametrised multi-cycle adder/subtractor: computes a+b or a-b on WIDTH-bit operands, DIGIT bits per cycle, LSB digit first.

---
 rtl/addsub_digit_serial.sv | 138 +++++++++++++
 tb/tb_addsub_digit_serial.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_digit_serial.sv
// rtl/addsub_digit_serial.sv - digit-serial add/sub, LSB digit first, with flags, optional saturation and valid/ready handshakes
module addsub_digit_serial #(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 4,
  parameter int SIGNED = 1,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic              r_sub;
  logic [KW-1:0]     r_k;
  logic [WIDTH-1:0]  r_s;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;
  logic              r_neg;

  logic [DIGIT-1:0]  w_a_dig;
  logic [DIGIT-1:0]  w_b_dig;
  logic [DIGIT:0]    w_dsum;
  logic [WIDTH-1:0]  w_sum_next;
  logic              w_last;
  logic              w_cin_msb;
  logic              w_ovf_raw;
  logic [WIDTH-1:0]  w_s_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_k == KW'(i)) begin
        w_a_dig = r_a[i*DIGIT +: DIGIT];
        w_b_dig = r_b[i*DIGIT +: DIGIT];
      end
    end
    w_dsum     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    w_sum_next = r_sum;
    for (int i = 0; i < NDIG; i++) begin
      if (r_k == KW'(i)) w_sum_next[i*DIGIT +: DIGIT] = w_dsum[DIGIT-1:0];
    end
    w_last    = (r_k == KW'(NDIG - 1));
    // Carry into the MSB recovered from the MSB sum bit for the signed overflow rule
    w_cin_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_next[WIDTH-1];
    if (SIGNED != 0) w_ovf_raw = w_cin_msb ^ w_dsum[DIGIT];
    else             w_ovf_raw = r_sub ? ~w_dsum[DIGIT] : w_dsum[DIGIT];
    w_s_final = w_sum_next;
    if ((SAT != 0) && w_ovf_raw) begin
      if (SIGNED != 0) w_s_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else             w_s_final = r_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b ^ {WIDTH{sub}};
        r_carry <= sub;
        r_sub   <= sub;
        r_k     <= '0;
        r_sum   <= '0;
      end
    end else if (r_state == ST_RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_dsum[DIGIT];
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_s    <= w_s_final;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_ovf_raw;
        r_zero <= (w_s_final == '0);
        r_neg  <= w_s_final[WIDTH-1];
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
  assign neg  = r_neg;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// tb/tb_addsub_digit_serial.sv - bench for addsub_digit_serial over five parameter variants
module tb_addsub_digit_serial;

  localparam int NI = 5;
  localparam int SGN  [NI] = '{1, 0, 0, 1, 1};
  localparam int SATP [NI] = '{0, 0, 1, 1, 0};
  localparam int NDG  [NI] = '{4, 4, 4, 4, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, sub, out_ready;
  logic [15:0]   a, b;
  logic [NI-1:0] in_ready_v, out_valid_v, cout_v, ovf_v, zero_v, neg_v;
  logic [15:0]   s_v [NI];

  int nvec = 0;
  int nmis = 0;

  genvar g;
  for (g = 0; g < NI; g++) begin : g_dut
    addsub_digit_serial #(
      .WIDTH(16), .DIGIT(16 / NDG[g]), .SIGNED(SGN[g]), .SAT(SATP[g])
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[g]),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[g]), .out_ready(out_ready),
      .s(s_v[g]), .cout(cout_v[g]), .ovf(ovf_v[g]), .zero(zero_v[g]), .neg(neg_v[g])
    );
  end

  typedef struct {
    logic [15:0] s;
    logic        cout, ovf, zero, neg;
  } res_t;

  typedef struct {
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] s;
    logic        cout, ovf;
  } vec_t;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic sb, input int sg, input int st);
    res_t r;
    int ux, uy, sx, sy, uraw, sraw;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    uraw = sb ? ux - uy : ux + uy;
    sraw = sb ? sx - sy : sx + sy;
    r.s    = 16'(uraw);
    r.cout = sb ? (ux >= uy) : (uraw > 65535);
    if (sg != 0) r.ovf = (sraw > 32767) || (sraw < -32768);
    else         r.ovf = sb ? (ux < uy) : (uraw > 65535);
    if (st != 0 && r.ovf) begin
      if (sg != 0) r.s = (sraw > 0) ? 16'h7FFF : 16'h8000;
      else         r.s = sb ? 16'h0000 : 16'hFFFF;
    end
    r.zero = (r.s == 16'h0000);
    r.neg  = r.s[15];
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s inst%0d got=%h want=%h", nm, i, got, exp);
    end
  endtask

  function automatic logic [20:0] pack_out(input int i);
    return {s_v[i], cout_v[i], ovf_v[i], zero_v[i], neg_v[i]};
  endfunction

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic sb, input int hold);
    int   lat [NI];
    res_t e [NI];
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1;
      e[i]   = model(x, y, sb, SGN[i], SATP[i]);
    end
    @(negedge clk);
    chk("idle_ready", 0, 32'(in_ready_v), 32'h1F);
    a = x; b = y; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~sb;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NI; i++)
        if (out_valid_v[i] && lat[i] < 0) lat[i] = c;
      if (&out_valid_v) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      chk("latency", i, 32'(lat[i]), 32'(NDG[i]));
      chk("result", i, 32'(pack_out(i)), 32'({e[i].s, e[i].cout, e[i].ovf, e[i].zero, e[i].neg}));
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_hs", 0, 32'({in_ready_v, out_valid_v}), 32'({5'h00, 5'h1F}));
        chk("hold_val", 0, 32'(pack_out(0)), 32'({e[0].s, e[0].cout, e[0].ovf, e[0].zero, e[0].neg}));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_hs", 0, 32'({in_ready_v, out_valid_v}), 32'({5'h1F, 5'h00}));
    chk("kept_val", 0, 32'(pack_out(0)), 32'({e[0].s, e[0].cout, e[0].ovf, e[0].zero, e[0].neg}));
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    logic [15:0] ra, rb;
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      chk("reset", i, 32'({pack_out(i), out_valid_v[i], in_ready_v[i]}), 32'({21'h0, 1'b0, 1'b1}));
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      do_op(tbl[t].a, tbl[t].b, tbl[t].sub, 0);
      chk("table", t, 32'({s_v[0], cout_v[0], ovf_v[0]}), 32'({tbl[t].s, tbl[t].cout, tbl[t].ovf}));
    end

    do_op(16'h0005, 16'h0007, 1'b1, 10);

    // Abort mid-run: two RUN edges, then asynchronous reset
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      chk("rst_abort", i, 32'({pack_out(i), out_valid_v[i]}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 0, 32'(in_ready_v), 32'h1F);
    do_op(16'h00FF, 16'h0001, 1'b0, 0);
    chk("post_rst_sum", 0, 32'(s_v[0]), 32'h0100);

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 4))
        0: ra = {ra[15], 15'h7FFF};
        1: rb = ra;
        2: rb = {1'b1, 15'h0};
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), (n % 8 == 3) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
